sdram_traffic_chk: RTL and testbench

//  Parametrised, synthesizable traffic generator and checker for sdram_ctrl_top.
//  On start it writes NUM_WORDS pattern words from BASE_ADDR through the

---
 rtl/sdram_traffic_chk_if.sv | 24 ++
 rtl/sdram_traffic_chk.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_traffic_chk.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_traffic_chk_if.sv
// User-port command and read-return bundle between the traffic checker (master)
// and the SDRAM controller user port (slave).
interface sdram_traffic_chk_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic              cmd_req;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_req, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ack, rd_valid, rd_data
  );

  modport slave (
    input  cmd_req, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/sdram_traffic_chk.sv
// Write/read-back traffic generator and checker for the SDRAM controller user port.
// Writes NUM_WORDS pattern words from BASE_ADDR, reads them back and tallies mismatches.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; status of last pass held
//   S_WR    | write command for word idx presented, waiting for ack
//   S_RD    | read command for word idx presented, waiting for ack
//   S_RWAIT | one read outstanding, waiting for rd_valid
//   S_FIN   | one cycle: publish done/pass, drop busy
module sdram_traffic_chk #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 256,
  parameter int                TIMEOUT   = 1024,
  parameter logic [31:0]       LFSR_SEED = 32'hACE1
) (
  input  logic                sclk,
  input  logic                snrst,
  input  logic                start,
  input  logic [1:0]          pat_sel,
  sdram_traffic_chk_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_cnt,
  output logic [ADDR_W-1:0]   first_err
);

  localparam int IDX_W = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] WALK_INIT = DATA_W'(1);
  localparam logic [DATA_W-1:0] CHK_ODD   = {(DATA_W/2){2'b01}};
  localparam logic [DATA_W-1:0] CHK_EVEN  = {(DATA_W/2){2'b10}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RWAIT = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       lfsr_q;
  logic [DATA_W-1:0] walk_q;
  logic [1:0]        pat_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              mis_seen_q;

  logic              step, rewind, tmr_load, to_hit, chk_en;
  logic              lfsr_fb, mismatch, spur;
  logic [ADDR_W-1:0] addr_cur;
  logic [DATA_W-1:0] pat_cur;

  assign lfsr_fb  = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
  assign addr_cur = BASE_ADDR + idx_q[ADDR_W-1:0];

  always_comb begin
    pat_cur = '0;
    unique case (pat_q)
      2'd0:    pat_cur = idx_q[DATA_W-1:0];
      2'd1:    pat_cur = lfsr_q[DATA_W-1:0];
      2'd2:    pat_cur = walk_q;
      default: pat_cur = idx_q[0] ? CHK_ODD : CHK_EVEN;
    endcase
  end

  assign mismatch = bus.rd_data != pat_cur;
  assign spur     = bus.rd_valid && (state_q != S_RWAIT);

  // Command fields are decoded from the registered state so a reset drops them at once.
  assign bus.cmd_req   = (state_q == S_WR) || (state_q == S_RD);
  assign bus.cmd_we    = (state_q == S_WR);
  assign bus.cmd_addr  = bus.cmd_req ? addr_cur : '0;
  assign bus.cmd_wdata = bus.cmd_we ? pat_cur : '0;

  always_comb begin
    state_d  = state_q;
    step     = 1'b0;
    rewind   = 1'b0;
    tmr_load = 1'b0;
    to_hit   = 1'b0;
    chk_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_load = 1'b1;
        if (start) begin
          rewind  = 1'b1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (bus.cmd_ack) begin
          tmr_load = 1'b1;
          if (idx_q == LAST_IDX) begin
            rewind  = 1'b1;
            state_d = S_RD;
          end else begin
            step = 1'b1;
          end
        end else if (tmr_q == '0) begin
          to_hit  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_RD: begin
        if (bus.cmd_ack) begin
          tmr_load = 1'b1;
          state_d  = S_RWAIT;
        end else if (tmr_q == '0) begin
          to_hit  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_RWAIT: begin
        if (bus.rd_valid) begin
          tmr_load = 1'b1;
          chk_en   = 1'b1;
          step     = 1'b1;
          state_d  = (idx_q == LAST_IDX) ? S_FIN : S_RD;
        end else if (tmr_q == '0) begin
          to_hit  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        tmr_load = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge snrst) begin
    if (!snrst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      walk_q     <= WALK_INIT;
      pat_q      <= 2'd0;
      tmr_q      <= TMR_LOAD;
      mis_seen_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= '0;
      first_err  <= '0;
    end else begin
      state_q <= state_d;

      // Wait timer counts down to a terminal count of zero.
      if (tmr_load)
        tmr_q <= TMR_LOAD;
      else if (tmr_q != '0)
        tmr_q <= tmr_q - TMR_W'(1);

      if (rewind) begin
        idx_q  <= '0;
        lfsr_q <= LFSR_SEED;
        walk_q <= WALK_INIT;
      end else if (step) begin
        idx_q  <= idx_q + IDX_W'(1);
        lfsr_q <= {lfsr_q[30:0], lfsr_fb};
        walk_q <= {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
      end

      if ((state_q == S_IDLE) && start) begin
        pat_q      <= pat_sel;
        busy       <= 1'b1;
        done       <= 1'b0;
        pass       <= 1'b0;
        timeout    <= 1'b0;
        err_cnt    <= '0;
        first_err  <= '0;
        mis_seen_q <= 1'b0;
      end else begin
        if (to_hit)
          timeout <= 1'b1;
        if (state_q == S_FIN) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_cnt == '0) && !timeout;
        end
        if (((chk_en && mismatch) || spur) && (err_cnt != 16'hFFFF))
          err_cnt <= err_cnt + 16'd1;
        if (chk_en && mismatch && !mis_seen_q) begin
          first_err  <= addr_cur;
          mis_seen_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_traffic_chk.sv
// Self-checking bench: a behavioural SDRAM user-port responder plus a pattern/address
// reference model drive and score the traffic checker.
module tb_sdram_traffic_chk;

  localparam int BASE   = 24'hFFFFFE;
  localparam int NW     = 8;
  localparam int TO     = 40;
  localparam int RD_LAT = 3;

  logic        clk, rst_n, start;
  logic [1:0]  pat_sel;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [23:0] first_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit hold_ack, drop_rd, spur_arm;
  logic [15:0] mem  [int];
  logic [15:0] flip [int];
  int          wr_addr_q[$], rd_addr_q[$], wr_cyc_q[$], rd_cyc_q[$];
  logic [15:0] wr_data_q[$];
  int          rd_cnt = -1;
  int          rd_addr_p;
  bit          prev_wait;
  logic        prev_we;
  logic [23:0] prev_addr;
  logic [15:0] prev_wdata;

  sdram_traffic_chk_if #(.DATA_W(16), .ADDR_W(24)) bus ();

  sdram_traffic_chk #(
    .DATA_W(16), .ADDR_W(24), .BASE_ADDR(24'hFFFFFE),
    .NUM_WORDS(NW), .TIMEOUT(TO), .LFSR_SEED(32'hACE1)
  ) dut (
    .sclk(clk), .snrst(rst_n), .start(start), .pat_sel(pat_sel), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err(first_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] exp_pat(input int sel, input int i);
    logic [31:0] l;
    case (sel)
      0: return 16'(i % 65536);
      1: begin
        l = 32'hACE1;
        for (int k = 0; k < i; k++) l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        return l[15:0];
      end
      2: return 16'(1 << (i % 16));
      default: return (i % 2 == 1) ? 16'h5555 : 16'hAAAA;
    endcase
  endfunction

  function automatic int exp_addr(input int i);
    return (BASE + i) % (1 << 24);
  endfunction

  // Controller model: decides ack, stores writes, returns reads after RD_LAT cycles.
  always @(negedge clk) begin
    logic [15:0] v;
    if (!rst_n) begin
      bus.cmd_ack  = 1'b0;
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      rd_cnt       = -1;
      prev_wait    = 1'b0;
    end else begin
      if (prev_wait) begin
        n_vec++;
        if (!bus.cmd_req || bus.cmd_we !== prev_we || bus.cmd_addr !== prev_addr ||
            bus.cmd_wdata !== prev_wdata) begin
          n_err++;
          $display("FAIL cmd_stable: got req=%0b we=%0b addr=%0h data=%0h, held we=%0b addr=%0h data=%0h",
                   bus.cmd_req, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, prev_we, prev_addr, prev_wdata);
        end
      end
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          if (!drop_rd) begin
            v = mem.exists(rd_addr_p) ? mem[rd_addr_p] : 16'h0000;
            if (flip.exists(rd_addr_p)) v = v ^ flip[rd_addr_p];
            bus.rd_valid = 1'b1;
            bus.rd_data  = v;
          end
          rd_cnt = -1;
        end
      end
      if (spur_arm && bus.cmd_req && bus.cmd_we) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = 16'($urandom);
        spur_arm     = 1'b0;
      end
      bus.cmd_ack = 1'b0;
      prev_wait   = 1'b0;
      if (bus.cmd_req) begin
        if (hold_ack || $urandom_range(0, 2) == 0) begin
          bus.cmd_ack = 1'b1;
          if (bus.cmd_we) begin
            mem[int'(bus.cmd_addr)] = bus.cmd_wdata;
            wr_addr_q.push_back(int'(bus.cmd_addr));
            wr_data_q.push_back(bus.cmd_wdata);
            wr_cyc_q.push_back(cyc + 1);
          end else begin
            rd_addr_q.push_back(int'(bus.cmd_addr));
            rd_cyc_q.push_back(cyc + 1);
            rd_cnt    = RD_LAT;
            rd_addr_p = int'(bus.cmd_addr);
          end
        end else begin
          prev_wait  = 1'b1;
          prev_we    = bus.cmd_we;
          prev_addr  = bus.cmd_addr;
          prev_wdata = bus.cmd_wdata;
        end
      end
    end
  end

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    @(negedge clk); start = 1'b1; pat_sel = sel;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_pass(input logic [1:0] sel, output bit ok);
    clear_log();
    pulse_start(sel);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, pass, timeout, err_cnt, first_err, bus.cmd_req, bus.cmd_we,
         bus.cmd_addr, bus.cmd_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got busy=%0b done=%0b pass=%0b to=%0b err=%0h ferr=%0h req=%0b, want all 0",
               busy, done, pass, timeout, err_cnt, first_err, bus.cmd_req);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({busy, done, pass, bus.cmd_req} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_outs: got busy=%0b done=%0b pass=%0b req=%0b, want 0", busy, done, pass, bus.cmd_req);
    end
  endtask

  task automatic test_incr();
    bit ok;
    run_pass(2'd0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL incr_done_wait: got no done, want done"); end
    n_vec++;
    if (wr_addr_q.size() != NW || rd_addr_q.size() != NW) begin
      n_err++;
      $display("FAIL incr_counts: got %0d writes %0d reads, want %0d each", wr_addr_q.size(), rd_addr_q.size(), NW);
    end
    for (int i = 0; i < NW && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
      n_vec++;
      if (wr_addr_q[i] != exp_addr(i) || wr_data_q[i] !== exp_pat(0, i) || rd_addr_q[i] != exp_addr(i)) begin
        n_err++;
        $display("FAIL incr_word%0d: got waddr=%0h data=%0h raddr=%0h, want addr=%0h data=%0h",
                 i, wr_addr_q[i], wr_data_q[i], rd_addr_q[i], exp_addr(i), exp_pat(0, i));
      end
    end
    if (wr_cyc_q.size() == NW && rd_cyc_q.size() > 0) begin
      n_vec++;
      if (rd_cyc_q[0] <= wr_cyc_q[NW-1]) begin
        n_err++;
        $display("FAIL incr_order: got first read cycle %0d, want after last write %0d", rd_cyc_q[0], wr_cyc_q[NW-1]);
      end
    end
    n_vec++;
    if ({busy, done, pass, timeout} !== 4'b0110 || err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL incr_status: got busy=%0b done=%0b pass=%0b to=%0b err=%0d, want 0 1 1 0 0",
               busy, done, pass, timeout, err_cnt);
    end
  endtask

  task automatic test_checker_err();
    bit ok;
    int k;
    k = $urandom_range(0, NW - 1);
    flip.delete();
    flip[exp_addr(k)] = 16'h0001;
    run_pass(2'd3, ok);
    flip.delete();
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL chk_done_wait: got no done, want done"); end
    n_vec++;
    if (err_cnt !== 16'd1 || first_err !== 24'(exp_addr(k)) || pass !== 1'b0) begin
      n_err++;
      $display("FAIL chk_flip: got err=%0d ferr=%0h pass=%0b, want err=1 ferr=%0h pass=0",
               err_cnt, first_err, pass, exp_addr(k));
    end
    for (int i = 0; i < NW && i < wr_data_q.size(); i++) begin
      n_vec++;
      if (wr_data_q[i] !== exp_pat(3, i)) begin
        n_err++;
        $display("FAIL chk_wdata%0d: got %0h want %0h", i, wr_data_q[i], exp_pat(3, i));
      end
    end
  endtask

  task automatic test_lfsr();
    bit ok;
    run_pass(2'd1, ok);
    n_vec++;
    if (!ok || wr_data_q.size() != NW || rd_addr_q.size() != NW) begin
      n_err++;
      $display("FAIL lfsr_run: got done=%0b writes=%0d reads=%0d, want 1 %0d %0d", ok, wr_data_q.size(), rd_addr_q.size(), NW, NW);
    end
    if (wr_data_q.size() > 0) begin
      n_vec++;
      if (wr_data_q[0] !== 16'hACE1) begin
        n_err++;
        $display("FAIL lfsr_word0: got %0h want ace1", wr_data_q[0]);
      end
    end
    for (int i = 1; i < wr_data_q.size(); i++) begin
      n_vec++;
      if (wr_data_q[i] !== exp_pat(1, i)) begin
        n_err++;
        $display("FAIL lfsr_word%0d: got %0h want %0h", i, wr_data_q[i], exp_pat(1, i));
      end
    end
    n_vec++;
    if (pass !== 1'b1 || err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL lfsr_pass: got pass=%0b err=%0d, want 1 0", pass, err_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok, seen, req_at;
    int t_cyc;
    drop_rd = 1'b1;
    clear_log();
    pulse_start(2'd0);
    ok = 1'b0; seen = 1'b0; req_at = 1'b1; t_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (timeout && !seen) begin seen = 1'b1; t_cyc = cyc; req_at = bus.cmd_req; end
      if (done) begin ok = 1'b1; break; end
    end
    drop_rd = 1'b0;
    n_vec++;
    if (!ok || !seen) begin n_err++; $display("FAIL to_wait: got done=%0b timeout_seen=%0b, want 1 1", ok, seen); end
    n_vec++;
    if (rd_cyc_q.size() != 1 || wr_addr_q.size() != NW) begin
      n_err++;
      $display("FAIL to_counts: got %0d reads %0d writes, want 1 %0d", rd_cyc_q.size(), wr_addr_q.size(), NW);
    end else begin
      n_vec++;
      if (t_cyc - rd_cyc_q[0] != TO) begin
        n_err++;
        $display("FAIL to_latency: got %0d cycles, want %0d", t_cyc - rd_cyc_q[0], TO);
      end
    end
    n_vec++;
    if (req_at !== 1'b0 || done !== 1'b1 || pass !== 1'b0 || timeout !== 1'b1) begin
      n_err++;
      $display("FAIL to_status: got req=%0b done=%0b pass=%0b to=%0b, want 0 1 0 1", req_at, done, pass, timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    pulse_start(2'd0);
    for (int c = 0; c < 500 && wr_addr_q.size() < 3; c++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, pass, timeout, err_cnt, first_err, bus.cmd_req, bus.cmd_we,
         bus.cmd_addr, bus.cmd_wdata} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outs: got busy=%0b req=%0b we=%0b addr=%0h data=%0h, want all 0",
               busy, bus.cmd_req, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_pass(2'd0, ok);
    n_vec++;
    if (!ok || wr_addr_q.size() == 0) begin
      n_err++;
      $display("FAIL rstmid_restart: got done=%0b writes=%0d, want a full pass", ok, wr_addr_q.size());
    end else begin
      n_vec++;
      if (wr_addr_q[0] != BASE || wr_data_q[0] !== 16'h0000 || wr_addr_q.size() != NW || pass !== 1'b1) begin
        n_err++;
        $display("FAIL rstmid_first: got addr=%0h data=%0h n=%0d pass=%0b, want %0h 0 %0d 1",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q.size(), pass, BASE, NW);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    hold_ack = 1'b1;
    clear_log();
    pulse_start(2'd2);
    @(negedge clk);
    start = 1'b1; pat_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    #1;
    hold_ack = 1'b0;
    n_vec++;
    if (!ok || wr_cyc_q.size() != NW || rd_addr_q.size() != NW || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_run: got done=%0b writes=%0d reads=%0d busy=%0b, want 1 %0d %0d 0",
               ok, wr_cyc_q.size(), rd_addr_q.size(), busy, NW, NW);
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      n_vec++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != 1) begin
        n_err++;
        $display("FAIL b2b_gap%0d: got %0d cycles between writes, want 1", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
    for (int i = 0; i < wr_data_q.size(); i++) begin
      n_vec++;
      if (wr_data_q[i] !== exp_pat(2, i) || wr_addr_q[i] != exp_addr(i)) begin
        n_err++;
        $display("FAIL b2b_word%0d: got addr=%0h data=%0h, want %0h %0h",
                 i, wr_addr_q[i], wr_data_q[i], exp_addr(i), exp_pat(2, i));
      end
    end
    n_vec++;
    if (pass !== 1'b1) begin n_err++; $display("FAIL b2b_pass: got %0b want 1", pass); end
  endtask

  task automatic test_spurious();
    bit ok;
    spur_arm = 1'b1;
    run_pass(2'd3, ok);
    spur_arm = 1'b0;
    n_vec++;
    if (!ok || err_cnt !== 16'd1 || first_err !== 24'd0 || pass !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL spur_status: got done=%0b err=%0d ferr=%0h pass=%0b, want 1 1 0 0",
               ok, err_cnt, first_err, pass);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      bit ok;
      int sel, nfl, cnt, first;
      sel = $urandom_range(0, 3);
      nfl = $urandom_range(0, 3);
      flip.delete();
      for (int f = 0; f < nfl; f++)
        flip[exp_addr($urandom_range(0, NW - 1))] = 16'(1 << $urandom_range(0, 15));
      cnt = flip.num();
      first = -1;
      for (int i = NW - 1; i >= 0; i--)
        if (flip.exists(exp_addr(i))) first = i;
      run_pass(2'(sel), ok);
      flip.delete();
      n_vec++;
      if (!ok || err_cnt !== 16'(cnt) || pass !== (cnt == 0) ||
          first_err !== ((first < 0) ? 24'd0 : 24'(exp_addr(first)))) begin
        n_err++;
        $display("FAIL rand%0d_status: sel=%0d got done=%0b err=%0d ferr=%0h pass=%0b, want err=%0d ferr=%0h",
                 it, sel, ok, err_cnt, first_err, pass, cnt, (first < 0) ? 0 : exp_addr(first));
      end
      for (int i = 0; i < wr_data_q.size(); i++) begin
        n_vec++;
        if (wr_data_q[i] !== exp_pat(sel, i)) begin
          n_err++;
          $display("FAIL rand%0d_word%0d: got %0h want %0h", it, i, wr_data_q[i], exp_pat(sel, i));
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; pat_sel = 2'd0;
    hold_ack = 1'b0; drop_rd = 1'b0; spur_arm = 1'b0;
    test_reset();
    test_incr();
    test_checker_err();
    test_lfsr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
